// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if - bundle of the per-channel SR bank signals.
//   en      : per-channel update enable
//   s_n     : per-channel active-low set
//   r_n     : per-channel active-low reset
//   err_clr : synchronous clear of the error flags and counter
//   q, q_n  : registered channel state and its inverse
//   err     : sticky per-channel violation flags
//   err_any : OR of the err flags
//   err_cnt : saturating count of cycles containing a violation
// The master modport drives the control inputs; the slave modport is the bank.
interface sr_ff_bank_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] en;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] r_n;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] err;
    logic             err_any;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, s_n, r_n, err_clr,
        input  q, q_n, err, err_any, err_cnt
    );

    modport slave (
        input  en, s_n, r_n, err_clr,
        output q, q_n, err, err_any, err_cnt
    );
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank - bank of WIDTH edge-triggered SR flip-flops with active-low
// set/reset, per-channel enable, a selectable policy for the forbidden
// "both asserted" input, sticky per-channel error flags and a saturating
// violation-cycle counter.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (q <= RESET_VAL, errors cleared)
//   bus   : sr_ff_bank_if slave (en, s_n, r_n, err_clr in; q, q_n, err,
//           err_any, err_cnt out). Every output is a register.
// INVALID_MODE: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
module sr_ff_bank #(
    parameter int               WIDTH        = 4,
    parameter int               INVALID_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int               CNT_W        = 8
) (
    input logic          clk,
    input logic          rst_n,
    sr_ff_bank_if.slave  bus
);

    logic [WIDTH-1:0] q_p0;
    logic [WIDTH-1:0] q_n_p0;
    logic [WIDTH-1:0] err_p0;
    logic             err_any_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic [WIDTH-1:0] viol;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Next state of one channel given its enable, set/reset and current value.
    function automatic logic sr_next(input logic e, input logic s, input logic r,
                                     input logic cur);
        logic nxt;
        nxt = cur;
        if (e) begin
            case ({s, r})
                2'b01:   nxt = 1'b1;
                2'b10:   nxt = 1'b0;
                2'b00: begin
                    case (INVALID_MODE)
                        1:       nxt = 1'b1;
                        2:       nxt = 1'b0;
                        3:       nxt = ~cur;
                        default: nxt = cur;
                    endcase
                end
                default: nxt = cur;
            endcase
        end
        return nxt;
    endfunction

    always_comb begin
        viol  = bus.en & ~bus.s_n & ~bus.r_n;
        q_nxt = q_p0;
        for (int i = 0; i < WIDTH; i++) begin
            q_nxt[i] = sr_next(bus.en[i], bus.s_n[i], bus.r_n[i], q_p0[i]);
        end

        // A clear and a fresh violation in the same cycle: the new event wins.
        err_nxt = bus.err_clr ? viol : (err_p0 | viol);

        cnt_nxt = cnt_p0;
        if (bus.err_clr) begin
            cnt_nxt = (|viol) ? CNT_W'(1) : '0;
        end else if (|viol) begin
            cnt_nxt = sat_inc(cnt_p0);
        end
    end

    // ---- stage p0: registered state and outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_p0       <= RESET_VAL;
            q_n_p0     <= ~RESET_VAL;
            err_p0     <= '0;
            err_any_p0 <= 1'b0;
            cnt_p0     <= '0;
        end else begin
            q_p0       <= q_nxt;
            q_n_p0     <= ~q_nxt;
            err_p0     <= err_nxt;
            err_any_p0 <= |err_nxt;
            cnt_p0     <= cnt_nxt;
        end
    end

    assign bus.q       = q_p0;
    assign bus.q_n     = q_n_p0;
    assign bus.err     = err_p0;
    assign bus.err_any = err_any_p0;
    assign bus.err_cnt = cnt_p0;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four instances (INVALID_MODE 0..3) share one
// stimulus stream. A behavioural model predicts each instance's outputs when
// a step is driven; the predictions are queued and compared after the edge.
module tb_sr_ff_bank;

    localparam int         W    = 4;
    localparam int         CW   = 3;
    localparam logic [3:0] RVAL = 4'b1010;

    typedef struct {
        int         mode;
        logic [3:0] q;
        logic [3:0] err;
        logic       err_any;
        logic [2:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] en, s_n, r_n;
    logic err_clr;

    always #5 clk = ~clk;

    sr_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus0 ();
    sr_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus1 ();
    sr_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus2 ();
    sr_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus3 ();

    assign bus0.en = en; assign bus0.s_n = s_n; assign bus0.r_n = r_n; assign bus0.err_clr = err_clr;
    assign bus1.en = en; assign bus1.s_n = s_n; assign bus1.r_n = r_n; assign bus1.err_clr = err_clr;
    assign bus2.en = en; assign bus2.s_n = s_n; assign bus2.r_n = r_n; assign bus2.err_clr = err_clr;
    assign bus3.en = en; assign bus3.s_n = s_n; assign bus3.r_n = r_n; assign bus3.err_clr = err_clr;

    sr_ff_bank #(.WIDTH(W), .INVALID_MODE(0), .RESET_VAL(RVAL), .CNT_W(CW))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sr_ff_bank #(.WIDTH(W), .INVALID_MODE(1), .RESET_VAL(RVAL), .CNT_W(CW))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sr_ff_bank #(.WIDTH(W), .INVALID_MODE(2), .RESET_VAL(RVAL), .CNT_W(CW))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    sr_ff_bank #(.WIDTH(W), .INVALID_MODE(3), .RESET_VAL(RVAL), .CNT_W(CW))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic [3:0] o_q [4];
    logic [3:0] o_qn [4];
    logic [3:0] o_err [4];
    logic       o_any [4];
    logic [2:0] o_cnt [4];

    assign o_q[0] = bus0.q; assign o_qn[0] = bus0.q_n; assign o_err[0] = bus0.err;
    assign o_any[0] = bus0.err_any; assign o_cnt[0] = bus0.err_cnt;
    assign o_q[1] = bus1.q; assign o_qn[1] = bus1.q_n; assign o_err[1] = bus1.err;
    assign o_any[1] = bus1.err_any; assign o_cnt[1] = bus1.err_cnt;
    assign o_q[2] = bus2.q; assign o_qn[2] = bus2.q_n; assign o_err[2] = bus2.err;
    assign o_any[2] = bus2.err_any; assign o_cnt[2] = bus2.err_cnt;
    assign o_q[3] = bus3.q; assign o_qn[3] = bus3.q_n; assign o_err[3] = bus3.err;
    assign o_any[3] = bus3.err_any; assign o_cnt[3] = bus3.err_cnt;

    // Reference model state, one slot per policy.
    logic [3:0] m_q [4];
    logic [3:0] m_err [4];
    logic [2:0] m_cnt [4];

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int mode,
                         input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s mode%0d observed=%0h expected=%0h", tag, mode, obs, exp);
        end
    endtask

    // Predict every policy's response to the inputs now on the pins.
    task automatic predict();
        for (int m = 0; m < 4; m++) begin
            exp_t e;
            logic any_v;
            logic [3:0] vbits;
            if (!rst_n) begin
                m_q[m]   = RVAL;
                m_err[m] = 4'b0000;
                m_cnt[m] = 3'd0;
            end else begin
                vbits = 4'b0000;
                for (int b = 0; b < 4; b++) begin
                    if (en[b] == 1'b1) begin
                        if (s_n[b] == 1'b0 && r_n[b] == 1'b1) m_q[m][b] = 1'b1;
                        else if (s_n[b] == 1'b1 && r_n[b] == 1'b0) m_q[m][b] = 1'b0;
                        else if (s_n[b] == 1'b0 && r_n[b] == 1'b0) begin
                            vbits[b] = 1'b1;
                            if (m == 1) m_q[m][b] = 1'b1;
                            else if (m == 2) m_q[m][b] = 1'b0;
                            else if (m == 3) m_q[m][b] = !m_q[m][b];
                        end
                    end
                end
                any_v = (vbits != 4'b0000);
                if (err_clr) begin
                    m_err[m] = vbits;
                    m_cnt[m] = any_v ? 3'd1 : 3'd0;
                end else begin
                    m_err[m] = m_err[m] | vbits;
                    if (any_v && m_cnt[m] != 3'd7) m_cnt[m] = m_cnt[m] + 3'd1;
                end
            end
            e.mode    = m;
            e.q       = m_q[m];
            e.err     = m_err[m];
            e.err_any = (m_err[m] != 4'b0000);
            e.cnt     = m_cnt[m];
            sb.push_back(e);
        end
    endtask

    // Drive one step, clock it, then retire the queued predictions.
    task automatic step(input string tag, input logic rst_v, input logic [3:0] en_v,
                        input logic [3:0] s_v, input logic [3:0] r_v, input logic clr_v);
        rst_n   = rst_v;
        en      = en_v;
        s_n     = s_v;
        r_n     = r_v;
        err_clr = clr_v;
        predict();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s scoreboard_underflow observed=0 expected=1", tag);
                break;
            end
            e = sb.pop_front();
            check({tag, ".q"},       e.mode, {4'h0, o_q[e.mode]},   {4'h0, e.q});
            check({tag, ".q_n"},     e.mode, {4'h0, o_qn[e.mode]},  {4'h0, ~e.q});
            check({tag, ".err"},     e.mode, {4'h0, o_err[e.mode]}, {4'h0, e.err});
            check({tag, ".err_any"}, e.mode, {7'h0, o_any[e.mode]}, {7'h0, e.err_any});
            check({tag, ".err_cnt"}, e.mode, {5'h0, o_cnt[e.mode]}, {5'h0, e.cnt});
        end
    endtask

    initial begin
        for (int m = 0; m < 4; m++) begin
            m_q[m] = RVAL; m_err[m] = '0; m_cnt[m] = '0;
        end
        rst_n = 1'b0; en = '0; s_n = '1; r_n = '1; err_clr = 1'b0;
        @(negedge clk);

        // Reset for two cycles with conflicting inputs present.
        step("reset1",     1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0);
        step("reset2",     1'b0, 4'b1111, 4'b0101, 4'b1111, 1'b0);
        step("rel_hold",   1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        step("hold11",     1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b0);
        // Set, reset, then disabled channels ignore everything.
        step("set0",       1'b1, 4'b1111, 4'b1110, 4'b1111, 1'b0);
        step("clr0",       1'b1, 4'b1111, 4'b1111, 4'b1110, 1'b0);
        step("en_off",     1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Forbidden input on channel 0, twice, to exercise every policy.
        step("viol_a",     1'b1, 4'b0001, 4'b1110, 4'b1110, 1'b0);
        step("viol_b",     1'b1, 4'b0001, 4'b1110, 4'b1110, 1'b0);
        step("clear",      1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1);
        // Two channels violating together count as one cycle.
        step("multi",      1'b1, 4'b1111, 4'b1010, 4'b1010, 1'b0);
        step("clr_vs_new", 1'b1, 4'b1000, 4'b0111, 4'b0111, 1'b1);
        step("clr_alone",  1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1);
        // Nine violating cycles against a 3-bit counter.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("sat%0d", i), 1'b1, 4'b0001, 4'b1110, 4'b1110, 1'b0);
        end
        step("post_sat",   1'b1, 4'b0100, 4'b1011, 4'b1011, 1'b0);
        // Reset arriving alongside a set discards the set.
        step("rst_mid",    1'b0, 4'b0010, 4'b1101, 4'b1111, 1'b0);
        step("after_rst",  1'b1, 4'b0001, 4'b1110, 4'b1111, 1'b0);

        n_checks++;
        assert (sb.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
